// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state type and length-field width for the instruction-memory loader.
// Build option: IMEM_LOADER_CHECKSUM_EN adds the S_CSUM state for a trailing XOR checksum byte.
package imem_loader_pkg;
  localparam int LEN_W = 16;
`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_WRITE, S_DONE} state_t;
`endif
endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles little-endian bytes into one instruction word.
// Ports: i_clk/i_rst_n clock and async active-low reset, i_clr drops any partial word,
// i_push shifts i_data in, o_word is the assembled word, o_last flags the final byte of a word.
module byte_packer #(
  parameter int P_DATA_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_clr,
  input  logic                    i_push,
  input  logic [7:0]              i_data,
  output logic [P_DATA_WIDTH-1:0] o_word,
  output logic                    o_last
);
  localparam int NB = P_DATA_WIDTH / 8;
  localparam int CW = NB > 1 ? $clog2(NB) : 1;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [P_DATA_WIDTH-1:0] word_q, word_d;
  assign o_last = cnt_q == CW'(NB - 1);
  assign o_word = word_q;
  // bytes enter at the top and shift down, so the first byte ends in bits [7:0]
  always_comb begin
    cnt_d  = i_clr ? '0 : i_push ? (o_last ? '0 : cnt_q + 1'b1) : cnt_q;
    word_d = i_clr ? '0 : i_push ? (word_q >> 8) | (P_DATA_WIDTH'(i_data) << (P_DATA_WIDTH - 8)) : word_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory while stalling the core.
// Ports: i_clk, i_rst_n (async active-low); i_start/i_abort control; i_rx_valid/i_rx_data/o_rx_ready
// byte stream; o_we/o_waddr/o_wdata memory write port; o_core_stall, o_done pulse, sticky o_err.
// Build option: IMEM_LOADER_CHECKSUM_EN expects a trailing XOR-of-payload byte after the words.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int P_DATA_WIDTH = 32,
  parameter int P_ADDR_WIDTH = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic                    i_rx_valid,
  input  logic [7:0]              i_rx_data,
  output logic                    o_rx_ready,
  output logic                    o_we,
  output logic [P_ADDR_WIDTH-1:0] o_waddr,
  output logic [P_DATA_WIDTH-1:0] o_wdata,
  output logic                    o_core_stall,
  output logic                    o_done,
  output logic                    o_err
);
  localparam logic [LEN_W:0] MAX_N = (LEN_W + 1)'(2 ** P_ADDR_WIDTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
  logic [7:0] csum_q, csum_d;
`else
  localparam state_t S_TAIL = S_DONE;
`endif
  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, widx_q, widx_d, n;
  logic [7:0]       lo_q, lo_d;
  logic             hi_q, hi_d, err_q, err_d, rdy_q, rdy_d, we_q, we_d, stall_q, stall_d, done_q, done_d;
  logic             fire, over, pk_last;
  assign o_rx_ready   = rdy_q && !i_abort;
  assign o_we         = we_q;
  assign o_waddr      = widx_q[P_ADDR_WIDTH-1:0];
  assign o_core_stall = stall_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign fire         = i_rx_valid && o_rx_ready;
  assign n            = {i_rx_data, lo_q};
  assign over         = {1'b0, n} > MAX_N;
  byte_packer #(.P_DATA_WIDTH(P_DATA_WIDTH)) u_packer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (state_q == S_IDLE),
    .i_push (fire && state_q == S_DATA),
    .i_data (i_rx_data),
    .o_word (o_wdata),
    .o_last (pk_last)
  );
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    widx_d  = widx_q;
    err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      S_IDLE: if (i_start) begin
        state_d = S_LEN;
        err_d   = 1'b0;
        widx_d  = '0;
        hi_d    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = '0;
`endif
      end
      S_LEN: if (fire) begin
        lo_d = i_rx_data;
        hi_d = 1'b1;
        if (hi_q) begin
          len_d   = n;
          err_d   = over;
          state_d = over ? S_IDLE : n == '0 ? S_TAIL : S_DATA;
        end
      end
      S_DATA: if (fire) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q ^ i_rx_data;
`endif
        state_d = pk_last ? S_WRITE : S_DATA;
      end
      S_WRITE: begin
        widx_d  = widx_q + 1'b1;
        state_d = widx_d < len_q ? S_DATA : S_TAIL;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: if (fire) begin
        err_d   = i_rx_data != csum_q;
        state_d = i_rx_data == csum_q ? S_DONE : S_IDLE;
      end
`endif
      default: state_d = S_IDLE;
    endcase
    if (i_abort && state_q != S_IDLE) state_d = S_IDLE;
    rdy_d   = state_d == S_LEN || state_d == S_DATA
`ifdef IMEM_LOADER_CHECKSUM_EN
              || state_d == S_CSUM
`endif
              ;
    we_d    = state_d == S_WRITE;
    stall_d = state_d != S_IDLE;
    done_d  = state_d == S_DONE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      lo_q    <= '0;
      hi_q    <= 1'b0;
      widx_q  <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
      we_q    <= 1'b0;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      widx_q  <= widx_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      we_q    <= we_d;
      stall_q <= stall_d;
      done_q  <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven loads with a write scoreboard plus abort, reset and backpressure sequences.
module tb_imem_loader;
  localparam int DW = 32;
  localparam int AW = 10;
  logic          i_clk = 0, i_rst_n = 0, i_start = 0, i_abort = 0, i_rx_valid = 0;
  logic [7:0]    i_rx_data = 0;
  logic          o_rx_ready, o_we, o_core_stall, o_done, o_err;
  logic [AW-1:0] o_waddr;
  logic [DW-1:0] o_wdata;
  always #5 i_clk = ~i_clk;
  imem_loader #(.P_DATA_WIDTH(DW), .P_ADDR_WIDTH(AW)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_abort     (i_abort),
    .i_rx_valid  (i_rx_valid),
    .i_rx_data   (i_rx_data),
    .o_rx_ready  (o_rx_ready),
    .o_we        (o_we),
    .o_waddr     (o_waddr),
    .o_wdata     (o_wdata),
    .o_core_stall(o_core_stall),
    .o_done      (o_done),
    .o_err       (o_err)
  );
  typedef struct {
    logic [15:0] len;
    logic [31:0] w0;
    logic [31:0] w1;
    logic        err;
    int          done;
  } vec_t;
  logic [AW+DW-1:0] exp_q[$];
  int n_cmp = 0, n_bad = 0, done_cnt = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge i_clk) begin
    if (o_done) done_cnt++;
    if (o_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", o_waddr, o_wdata);
      end else check("write", {o_waddr, o_wdata}, exp_q.pop_front());
    end
  end
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t = 0;
    i_rx_valid = 1;
    i_rx_data  = b;
    @(negedge i_clk);
    while (!o_rx_ready && t < 20) begin
      t++;
      @(negedge i_clk);
    end
    if (!o_rx_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL rx_timeout: got ready 0 expected ready within 20 cycles");
    end
    @(posedge i_clk);
    #1;
    i_rx_valid = 0;
    repeat (gap) tick();
  endtask
  task automatic wait_idle();
    int t = 0;
    @(negedge i_clk);
    while (o_core_stall && t < 100) begin
      t++;
      @(negedge i_clk);
    end
    check("idle_timeout", o_core_stall, 0);
    #6;
  endtask
  function automatic logic [31:0] word_at(input logic [31:0] w0, input logic [31:0] w1, input int i);
    return i == 0 ? w0 : i == 1 ? w1 : w0 ^ (32'(i) * 32'h01000193);
  endfunction
  task automatic run_load(input logic [15:0] len, input logic [31:0] w0, input logic [31:0] w1,
                          input int gap, input bit bad_csum);
    logic [7:0]  cs = 0;
    logic [31:0] w;
    done_cnt = 0;
    i_start  = 1;
    tick();
    i_start  = 0;
    check("stall_on_start", o_core_stall, 1);
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
    if (len <= 16'd1024) begin
      for (int i = 0; i < int'(len); i++) begin
        w = word_at(w0, w1, i);
        exp_q.push_back({i[AW-1:0], w});
        for (int k = 0; k < 4; k++) begin
          cs ^= w[8*k+:8];
          send_byte(w[8*k+:8], gap);
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(bad_csum ? cs ^ 8'h01 : cs, gap);
`endif
    end
    wait_idle();
  endtask
  task automatic end_checks(input string name, input logic err, input int done);
    check({name, "_err"}, o_err, err);
    check({name, "_done"}, done_cnt, done);
    check({name, "_drain"}, exp_q.size(), 0);
    exp_q.delete();
  endtask
  vec_t v[7];
  initial begin
    v[0] = '{16'd2, 32'h00000013, 32'h00100093, 1'b0, 1};
    v[1] = '{16'd1025, 32'h0, 32'h0, 1'b1, 0};
    v[2] = '{16'd0, 32'h0, 32'h0, 1'b0, 1};
    v[3] = '{16'd3, 32'hDEADBEEF, 32'h12345678, 1'b0, 1};
    v[4] = '{16'd1024, 32'h0F0F0F0F, 32'hCAFEF00D, 1'b0, 1};
    v[5] = '{16'hFFFF, 32'h0, 32'h0, 1'b1, 0};
    v[6] = '{16'd1, 32'hFFFFFFFF, 32'h0, 1'b0, 1};
    #12;
    check("reset_outputs", {o_rx_ready, o_we, o_waddr, o_wdata, o_core_stall, o_done, o_err}, 0);
    tick();
    i_rst_n = 1;
    tick();
    for (int j = 0; j < 7; j++) begin
      run_load(v[j].len, v[j].w0, v[j].w1, 0, 1'b0);
      end_checks($sformatf("vec%0d", j), v[j].err, v[j].done);
    end
    // sticky error survives idle cycles and is cleared by the next start
    run_load(16'd1025, 32'h0, 32'h0, 0, 1'b0);
    repeat (3) tick();
    check("err_sticky", o_err, 1);
    i_start = 1;
    tick();
    i_start = 0;
    check("err_cleared_by_start", o_err, 0);
    i_abort = 1;
    tick();
    i_abort = 0;
    check("abort_from_len", o_core_stall, 0);
    // backpressure: valid low every other cycle
    run_load(16'd1, 32'hDEADBEEF, 32'h0, 1, 1'b0);
    end_checks("backpressure", 1'b0, 1);
    // abort after two payload bytes
    done_cnt = 0;
    i_start  = 1;
    tick();
    i_start  = 0;
    send_byte(8'd1, 0);
    send_byte(8'd0, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    i_abort = 1;
    #1;
    check("ready_low_on_abort", o_rx_ready, 0);
    tick();
    i_abort = 0;
    check("abort_stall", o_core_stall, 0);
    repeat (3) tick();
    end_checks("abort", 1'b0, 0);
    run_load(16'd1, 32'h11223344, 32'h0, 0, 1'b0);
    end_checks("after_abort", 1'b0, 1);
    // reset in S_DATA after one word has been written
    i_start = 1;
    tick();
    i_start = 0;
    send_byte(8'd2, 0);
    send_byte(8'd0, 0);
    exp_q.push_back({10'd0, 32'h44332211});
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    send_byte(8'h55, 0);
    check("pre_reset_addr", o_waddr, 1);
    check("pre_reset_stall", o_core_stall, 1);
    i_rst_n = 0;
    #1;
    check("reset_mid_load", {o_rx_ready, o_we, o_waddr, o_wdata, o_core_stall, o_done, o_err}, 0);
    tick();
    i_rst_n = 1;
    tick();
    check("reset_drain", exp_q.size(), 0);
    run_load(16'd2, 32'h00000013, 32'h00100093, 0, 1'b0);
    end_checks("after_reset", 1'b0, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    run_load(16'd1, 32'h00000013, 32'h0, 0, 1'b0);
    end_checks("csum_ok", 1'b0, 1);
    run_load(16'd1, 32'h00000013, 32'h0, 0, 1'b1);
    end_checks("csum_bad", 1'b1, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end
endmodule
